// File: rtl/div_sched.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Stalls the pipeline until {HI = remainder, LO = quotient} is ready.
module div_sched #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  input  logic                  stall_i,
  output logic                  stallreq_o,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e                 state_q;
  logic [2*DATA_W:0]      part_q;
  logic [DATA_W-1:0]      divisor_q;
  logic                   negQuo_q;
  logic                   negRem_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*DATA_W-1:0]    result_q;

  logic [DATA_W-1:0]      absA;
  logic [DATA_W-1:0]      absB;
  logic [DATA_W+1:0]      shiftedUp;
  logic [DATA_W+1:0]      diff;
  logic [2*DATA_W:0]      partStep_d;
  logic [DATA_W-1:0]      quoFix;
  logic [DATA_W-1:0]      remFix;

  always_comb begin
    absA = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    absB = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Upper half of the partial register after the one-bit left shift.
    shiftedUp = part_q[2*DATA_W:DATA_W-1];
    diff      = shiftedUp - {2'b00, divisor_q};
    if (!diff[DATA_W+1])
      partStep_d = {diff[DATA_W:0], part_q[DATA_W-2:0], 1'b1};
    else
      partStep_d = {shiftedUp[DATA_W:0], part_q[DATA_W-2:0], 1'b0};

    quoFix = negQuo_q ? -partStep_d[DATA_W-1:0] : partStep_d[DATA_W-1:0];
    remFix = negRem_q ? -partStep_d[2*DATA_W-1:DATA_W]
                      : partStep_d[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      part_q    <= '0;
      divisor_q <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (annul_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            part_q    <= {{(DATA_W+1){1'b0}}, absA};
            divisor_q <= absB;
            negQuo_q  <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            negRem_q  <= signed_i & opdata1_i[DATA_W-1];
            cnt_q     <= '0;
            state_q   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          result_q <= '0;
          state_q  <= S_END;
        end
        S_ON: begin
          part_q <= partStep_d;
          if (cnt_q == CNT_LAST) begin
            result_q <= {remFix, quoFix};
            state_q  <= S_END;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          // A stalled EX has not consumed the result yet, so hold it.
          if (!stall_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign ready_o    = (state_q == S_END) & ~annul_i;
  assign stallreq_o = ~annul_i & (((state_q == S_IDLE) & start_i) |
                                  (state_q == S_ON) | (state_q == S_BYZERO));
  assign result_o   = result_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: scoreboard of expected {HI,LO} results,
// latency/stall/annul/reset scenarios.
module tb_div_sched;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        stall_i;
  logic        stallreq_o;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;

  int passCount = 0;
  int checkCount = 0;
  logic [63:0] expQ[$];

  div_sched #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .stall_i(stall_i), .stallreq_o(stallreq_o), .busy_o(busy_o),
    .ready_o(ready_o), .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] modelDiv(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Launch one divide, follow it to END, optionally stall there, then consume.
  task automatic applyStimulus(input string tag, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input int stallCycles);
    int cycles;
    logic stallHigh;
    logic gotReady;
    logic [63:0] exp;
    expQ.push_back(modelDiv(s, a, b));
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
    @(negedge clk);
    checkOutput({tag, ".stallreqStart"}, {63'd0, stallreq_o}, 64'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    cycles = 0; stallHigh = 1'b1; gotReady = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (ready_o) begin
        gotReady = 1'b1;
        break;
      end
      if (!stallreq_o) stallHigh = 1'b0;
      @(posedge clk); #1;
    end
    if (!gotReady) begin
      checkOutput({tag, ".timeout"}, 64'd0, 64'd1);
      void'(expQ.pop_front());
      return;
    end
    checkOutput({tag, ".latency"}, 64'(cycles), (b == 32'd0) ? 64'd2 : 64'd33);
    checkOutput({tag, ".stallreqBusy"}, {63'd0, stallHigh}, 64'd1);
    checkOutput({tag, ".stallreqEnd"}, {63'd0, stallreq_o}, 64'd0);
    exp = expQ.pop_front();
    if (stallCycles > 0) begin
      stall_i = 1'b1;
      for (int k = 0; k < stallCycles; k++) begin
        @(posedge clk); #1;
        if (k == stallCycles - 1) stall_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".heldReady"}, {63'd0, ready_o}, 64'd1);
        checkOutput({tag, ".heldResult"}, result_o, exp);
      end
    end
    checkOutput({tag, ".result"}, result_o, exp);
  endtask

  initial begin
    int readySeen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    annul_i = 1'b0; stall_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.outs", {busy_o, ready_o, stallreq_o}, 64'd0);
    checkOutput("reset.result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("divu100_7", 1'b0, 32'd100, 32'd7, 0);
    applyStimulus("div-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus("div7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    applyStimulus("divOvf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("divu5_0", 1'b0, 32'd5, 32'd0, 0);
    applyStimulus("divuMax", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus("divStall", 1'b0, 32'd1000, 32'd33, 3);
    applyStimulus("divu8_2", 1'b0, 32'd8, 32'd2, 0);
    for (int r = 0; r < 4; r++)
      applyStimulus("random", 1'($urandom_range(1)), $urandom,
                    $urandom | 32'd1, 0);

    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul.mask", {62'd0, ready_o, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    readySeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o || stallreq_o || busy_o) readySeen++;
    end
    checkOutput("annul.quiet", 64'(readySeen), 64'd0);
    applyStimulus("divu9_3", 1'b0, 32'd9, 32'd3, 0);

    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd11;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    checkOutput("rstAsync.outs", {61'd0, busy_o, ready_o, stallreq_o}, 64'd0);
    checkOutput("rstAsync.result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    readySeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o || busy_o) readySeen++;
    end
    checkOutput("rstAsync.noReady", 64'(readySeen), 64'd0);
    applyStimulus("postRst", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
